// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave: FSM states, command layout
// and the register map.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int         CMD_RW_BIT  = 7;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_ID     = 3'd7;
  localparam int         NUM_RW_REGS = 6;

endpackage

// File: rtl/spi_sync.sv
// Brings sck/ss/mosi into the clk domain and turns sck/ss transitions into
// single-cycle event pulses.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sck,
  input  logic ss,
  input  logic mosi,
  output logic ss_sync,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_rise,
  output logic ss_fall
);

  logic [SYNC_STAGES-1:0] sck_pipe_r;
  logic [SYNC_STAGES-1:0] ss_pipe_r;
  logic [SYNC_STAGES-1:0] mosi_pipe_r;
  logic                   sck_prev_r;
  logic                   ss_prev_r;

  // Synchronizer chains run freely through reset, so a select held high
  // across a reset never appears as a fresh ss rise.
  always_ff @(posedge clk) begin
    sck_pipe_r  <= {sck_pipe_r[SYNC_STAGES-2:0], sck};
    ss_pipe_r   <= {ss_pipe_r[SYNC_STAGES-2:0], ss};
    mosi_pipe_r <= {mosi_pipe_r[SYNC_STAGES-2:0], mosi};
    sck_prev_r  <= sck_pipe_r[SYNC_STAGES-1];
    ss_prev_r   <= ss_pipe_r[SYNC_STAGES-1];
  end

  assign ss_sync   = ss_pipe_r[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe_r[SYNC_STAGES-1];
  assign sck_rise  = sck_pipe_r[SYNC_STAGES-1] & ~sck_prev_r;
  assign sck_fall  = ~sck_pipe_r[SYNC_STAGES-1] & sck_prev_r;
  assign ss_rise   = ss_pipe_r[SYNC_STAGES-1] & ~ss_prev_r;
  assign ss_fall   = ~ss_pipe_r[SYNC_STAGES-1] & ss_prev_r;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave exposing six R/W byte registers, a write counter and an ID
// byte. Everything runs on clk; sck is only oversampled.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 3,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sck,
  input  logic                          ss,
  input  logic                          mosi,
  output logic                          miso,
  output logic [NUM_RW_REGS*DATA_W-1:0] regs_out,
  output logic                          wr_pulse,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic                          busy
);

  logic ss_sync_s, mosi_sync_s;
  logic sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s;

  state_t                               state_r, state_nxt_s;
  logic [2:0]                           bit_cnt_r;
  logic [DATA_W-2:0]                    rx_sr_r;
  logic [DATA_W-1:0]                    tx_sr_r;
  logic                                 tx_hold_r;
  logic                                 rw_r;
  logic [ADDR_W-1:0]                    addr_r;
  logic [NUM_RW_REGS-1:0][DATA_W-1:0]   regs_r;
  logic [DATA_W-1:0]                    wr_cnt_r;
  logic                                 wr_pulse_r;
  logic [ADDR_W-1:0]                    wr_addr_r;
  logic                                 busy_r;

  logic [DATA_W-1:0] rx_byte_s;
  logic              byte_done_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;

  spi_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .sck       (sck),
    .ss        (ss),
    .mosi      (mosi),
    .ss_sync   (ss_sync_s),
    .mosi_sync (mosi_sync_s),
    .sck_rise  (sck_rise_s),
    .sck_fall  (sck_fall_s),
    .ss_rise   (ss_rise_s),
    .ss_fall   (ss_fall_s)
  );

  // The byte completing on this rise includes the bit being sampled now.
  assign rx_byte_s = {rx_sr_r, mosi_sync_s};

  // Next-state logic; an ss fall always wins over a completing byte.
  always_comb begin
    state_nxt_s = state_r;
    byte_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_rise_s) begin
          state_nxt_s = ST_CMD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ss_fall_s) begin
          state_nxt_s = ST_IDLE;
        end else if (sck_rise_s && (bit_cnt_r == 3'd7)) begin
          state_nxt_s = ST_DATA;
          byte_done_s = 1'b1;
        end else begin
          state_nxt_s = ST_CMD;
        end
      end
      ST_DATA: begin
        if (ss_fall_s) begin
          state_nxt_s = ST_IDLE;
        end else if (sck_rise_s && (bit_cnt_r == 3'd7)) begin
          state_nxt_s = ST_DATA;
          byte_done_s = 1'b1;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Read source: the command address itself, then the following address in a burst.
  always_comb begin
    if (state_r == ST_CMD) begin
      rd_addr_s = rx_byte_s[ADDR_W-1:0];
    end else begin
      rd_addr_s = addr_r + ADDR_W'(1);
    end
  end

  // Register map read mux.
  always_comb begin
    rd_data_s = '0;
    if (rd_addr_s < ADDR_STATUS) begin
      rd_data_s = regs_r[rd_addr_s];
    end else if (rd_addr_s == ADDR_STATUS) begin
      rd_data_s = wr_cnt_r;
    end else if (rd_addr_s == ADDR_ID) begin
      rd_data_s = ID_VALUE;
    end else begin
      rd_data_s = '0;
    end
  end

  // FSM state, shift registers, register bank and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      rx_sr_r    <= '0;
      tx_sr_r    <= '0;
      tx_hold_r  <= 1'b0;
      rw_r       <= 1'b0;
      addr_r     <= '0;
      regs_r     <= '0;
      wr_cnt_r   <= '0;
      wr_pulse_r <= 1'b0;
      wr_addr_r  <= '0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      wr_pulse_r <= 1'b0;
      if ((state_r == ST_IDLE) || ss_fall_s) begin
        bit_cnt_r <= 3'd0;
        tx_sr_r   <= '0;
        tx_hold_r <= 1'b0;
      end else begin
        if (sck_rise_s) begin
          rx_sr_r   <= rx_byte_s[DATA_W-2:0];
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        if (byte_done_s) begin
          if (state_r == ST_CMD) begin
            rw_r   <= rx_byte_s[CMD_RW_BIT];
            addr_r <= rx_byte_s[ADDR_W-1:0];
            if (rx_byte_s[CMD_RW_BIT]) begin
              tx_sr_r <= '0;
            end else begin
              tx_sr_r   <= rd_data_s;
              tx_hold_r <= 1'b1;
            end
          end else begin
            if (rw_r) begin
              tx_sr_r <= '0;
              if (addr_r < ADDR_STATUS) begin
                regs_r[addr_r] <= rx_byte_s;
                wr_pulse_r     <= 1'b1;
                wr_addr_r      <= addr_r;
                wr_cnt_r       <= wr_cnt_r + DATA_W'(1);
              end
            end else begin
              tx_sr_r   <= rd_data_s;
              tx_hold_r <= 1'b1;
            end
            addr_r <= addr_r + ADDR_W'(1);
          end
        end else if (sck_fall_s && (state_r == ST_DATA)) begin
          // The first fall after a load only presents bit 7; later falls shift.
          if (tx_hold_r) begin
            tx_hold_r <= 1'b0;
          end else begin
            tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign miso     = tx_sr_r[DATA_W-1] & ss_sync_s;
  assign regs_out = regs_r;
  assign wr_pulse = wr_pulse_r;
  assign wr_addr  = wr_addr_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed frames plus random bursts
// compared against a register-map model.
module tb_spi_reg_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic [47:0] regs_out;
  logic        wr_pulse;
  logic [2:0]  wr_addr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_regs [6];
  logic [7:0] m_cnt;

  int         pulse_cnt = 0;
  logic [2:0] pulse_log [256];

  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];

  always #5 clk = ~clk;

  spi_reg_slave dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso),
    .regs_out (regs_out),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      if (pulse_cnt < 256) pulse_log[pulse_cnt] = wr_addr;
      pulse_cnt = pulse_cnt + 1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a < 3'd6) return m_regs[a];
    else if (a == 3'd6) return m_cnt;
    else return 8'hA5;
  endfunction

  function automatic logic [47:0] m_packed();
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
    m_cnt = 8'h00;
  endtask

  // Shift out the top nbits of b, sampling miso just before each sck rise.
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      wait_clks(HALF);
      r[i] = miso;
      sck = 1'b1;
      wait_clks(HALF);
      sck = 1'b0;
    end
  endtask

  // Send tx_q as one complete frame and check it against the model.
  task automatic run_frame(input string name);
    logic [7:0] r, cmd, exp;
    logic [2:0] a;
    int p0, np;
    p0 = pulse_cnt;
    rx_q.delete();
    ss = 1'b1;
    wait_clks(HALF);
    foreach (tx_q[k]) begin
      spi_bits(tx_q[k], 8, r);
      rx_q.push_back(r);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_in_frame got=%b exp=1", name, busy);
    end
    wait_clks(4);
    ss = 1'b0;
    wait_clks(HALF);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_after got=%b exp=0", name, busy);
    end
    cmd = tx_q[0];
    a = cmd[2:0];
    np = 0;
    total++;
    if (rx_q[0] !== 8'h00) begin
      bad++; $display("FAIL %s cmd_miso got=%h exp=00", name, rx_q[0]);
    end
    for (int k = 1; k < tx_q.size(); k++) begin
      exp = cmd[7] ? 8'h00 : m_read(a);
      total++;
      if (rx_q[k] !== exp) begin
        bad++; $display("FAIL %s miso_byte%0d got=%h exp=%h", name, k, rx_q[k], exp);
      end
      if (cmd[7] && (a < 3'd6)) begin
        if (p0 + np < pulse_cnt) begin
          total++;
          if (pulse_log[p0 + np] !== a) begin
            bad++; $display("FAIL %s wr_addr got=%0d exp=%0d", name, pulse_log[p0 + np], a);
          end
        end
        m_regs[a] = tx_q[k];
        m_cnt = m_cnt + 8'd1;
        np++;
      end
      a = a + 3'd1;
    end
    total++;
    if (pulse_cnt - p0 !== np) begin
      bad++; $display("FAIL %s pulse_count got=%0d exp=%0d", name, pulse_cnt - p0, np);
    end
    total++;
    if (regs_out !== m_packed()) begin
      bad++; $display("FAIL %s regs_out got=%h exp=%h", name, regs_out, m_packed());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sck = 1'b0; ss = 1'b0; mosi = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    model_reset();
    wait_clks(1);
    total++;
    if ({regs_out, wr_pulse, wr_addr, busy, miso} !== 54'd0) begin
      bad++; $display("FAIL reset outputs got=%h exp=0", {regs_out, wr_pulse, wr_addr, busy, miso});
    end
    tx_q = '{8'h07, 8'h00};
    run_frame("read_id");
    tx_q = '{8'h00, 8'h00};
    run_frame("read_reg0");
    total++;
    if (pulse_cnt !== 0) begin
      bad++; $display("FAIL reset no_pulse got=%0d exp=0", pulse_cnt);
    end
  endtask

  task automatic test_write();
    tx_q = '{8'h82, 8'h3C};
    run_frame("write_reg2");
    total++;
    if (regs_out[23:16] !== 8'h3C) begin
      bad++; $display("FAIL write reg2 got=%h exp=3c", regs_out[23:16]);
    end
    tx_q = '{8'h06, 8'h00};
    run_frame("read_count");
  endtask

  task automatic test_burst_write();
    tx_q = '{8'h85, 8'h11, 8'h22, 8'h33};
    run_frame("burst_write_wrap");
  endtask

  task automatic test_burst_read();
    tx_q = '{8'h07, 8'h5A, 8'hC3};
    run_frame("burst_read_wrap");
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int p0;
    tx_q = '{8'h81, 8'h5A};
    run_frame("abort_setup");
    p0 = pulse_cnt;
    ss = 1'b1;
    wait_clks(HALF);
    spi_bits(8'h81, 8, r);
    spi_bits(8'hFF, 5, r);
    ss = 1'b0;
    wait_clks(HALF);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort busy got=%b exp=0", busy);
    end
    total++;
    if (pulse_cnt !== p0) begin
      bad++; $display("FAIL abort pulse got=%0d exp=%0d", pulse_cnt - p0, 0);
    end
    total++;
    if (regs_out !== m_packed()) begin
      bad++; $display("FAIL abort regs got=%h exp=%h", regs_out, m_packed());
    end
    tx_q = '{8'h01, 8'h00};
    run_frame("after_abort");
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int p0;
    tx_q = '{8'h80, 8'h99, 8'h44};
    run_frame("rst_setup");
    ss = 1'b1;
    wait_clks(HALF);
    spi_bits(8'h83, 8, r);
    spi_bits(8'hC3, 4, r);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if ({regs_out, busy, wr_pulse} !== 50'd0) begin
      bad++; $display("FAIL rst_mid outputs got=%h exp=0", {regs_out, busy, wr_pulse});
    end
    p0 = pulse_cnt;
    spi_bits(8'h30, 4, r);
    spi_bits(8'h77, 8, r);
    ss = 1'b0;
    wait_clks(HALF);
    total++;
    if (pulse_cnt !== p0 || regs_out !== 48'd0) begin
      bad++; $display("FAIL rst_mid ignored got=%0d/%h exp=0/0", pulse_cnt - p0, regs_out);
    end
    tx_q = '{8'h06, 8'h00};
    run_frame("rst_count");
    tx_q = '{8'h84, 8'hE7};
    run_frame("rst_rewrite");
  endtask

  task automatic test_random();
    int len;
    logic [7:0] cmd;
    for (int f = 0; f < 24; f++) begin
      cmd = 8'($urandom);
      tx_q.delete();
      tx_q.push_back(cmd);
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
      run_frame("random");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_write();
    test_burst_read();
    test_abort();
    test_reset_mid();
    test_random();
    test_burst_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
